// File: rtl/lc3b_cw_pipeline_if.sv
// Bundle of signals between decode/datapath and the LC-3b control-word
// pipeline. The pipeline owns the slave side. Decode and the datapath
// stall/flush logic own the master side.
interface lc3b_cw_pipeline_if #(
    parameter int CW_WIDTH  = 20,
    parameter int DEPTH     = 4,
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 16
);
    logic                         in_valid;
    logic [CW_WIDTH-1:0]          in_cw;
    logic [PC_WIDTH-1:0]          in_pc;
    logic                         in_ready;
    logic [DEPTH-1:0]             stall;
    logic [DEPTH-1:0]             flush;
    logic [DEPTH-1:0]             stage_valid;
    logic [DEPTH*CW_WIDTH-1:0]    stage_cw;
    logic [DEPTH*PC_WIDTH-1:0]    stage_pc;
    logic                         retire_valid;
    logic [CW_WIDTH-1:0]          retire_cw;
    logic [CNT_WIDTH-1:0]         retire_count;

    modport master (
        output in_valid, in_cw, in_pc, stall, flush,
        input  in_ready, stage_valid, stage_cw, stage_pc,
               retire_valid, retire_cw, retire_count
    );

    modport slave (
        input  in_valid, in_cw, in_pc, stall, flush,
        output in_ready, stage_valid, stage_cw, stage_pc,
               retire_valid, retire_cw, retire_count
    );
endinterface

// File: rtl/lc3b_cw_pipeline.sv
// Control-word pipeline for the LC-3b core.
// The decoded control word and its PC travel through DEPTH stages. Stage 0 is
// the youngest stage and DEPTH-1 is writeback. The pipeline supports
// per-stage stalls with bubble insertion, per-stage flushes and a count of
// retired instructions. DEPTH is meant to stay in 2..8.
module lc3b_cw_pipeline #(
    parameter int CW_WIDTH  = 20,
    parameter int DEPTH     = 4,
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    lc3b_cw_pipeline_if.slave  bus
);

    logic [DEPTH-1:0]     hold;
    logic                 retire_valid;

    logic                 valid_reg  [DEPTH];
    logic [CW_WIDTH-1:0]  cw_reg     [DEPTH];
    logic [PC_WIDTH-1:0]  pc_reg     [DEPTH];
    logic                 valid_next [DEPTH];
    logic [CW_WIDTH-1:0]  cw_next    [DEPTH];
    logic [PC_WIDTH-1:0]  pc_next    [DEPTH];
    logic [CNT_WIDTH-1:0] retire_count_reg;

    // A stall in any stage freezes that stage and every younger stage.
    always_comb begin : hold_chain
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc     = acc | bus.stall[k];
            hold[k] = acc;
        end
    end

    assign bus.in_ready = ~hold[0];

    // Per-stage next state. Flush wins over hold. Hold wins over advance.
    // Every source comes from pre-edge registers. A word leaving a flushed
    // stage therefore still moves into the next stage on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_next[gi] = bus.flush[gi] ? 1'b0 :
                                        hold[gi]      ? valid_reg[gi] :
                                                        bus.in_valid;
                assign cw_next[gi]    = bus.flush[gi] ? '0 :
                                        hold[gi]      ? cw_reg[gi] :
                                        bus.in_valid  ? bus.in_cw : '0;
                assign pc_next[gi]    = (bus.flush[gi] || hold[gi]) ? pc_reg[gi] :
                                        bus.in_valid  ? bus.in_pc : '0;
            end else begin : g_body
                // A stage that is free while its upstream stage is held
                // receives a bubble.
                assign valid_next[gi] = bus.flush[gi] ? 1'b0 :
                                        hold[gi]      ? valid_reg[gi] :
                                        hold[gi-1]    ? 1'b0 :
                                                        valid_reg[gi-1];
                assign cw_next[gi]    = bus.flush[gi] ? '0 :
                                        hold[gi]      ? cw_reg[gi] :
                                        hold[gi-1]    ? '0 :
                                                        cw_reg[gi-1];
                assign pc_next[gi]    = (bus.flush[gi] || hold[gi]) ? pc_reg[gi] :
                                        hold[gi-1]    ? '0 :
                                                        pc_reg[gi-1];
            end
        end
    endgenerate

    // The oldest stage retires unless it is stalled or killed this cycle.
    assign retire_valid     = valid_reg[DEPTH-1] & ~bus.stall[DEPTH-1] & ~bus.flush[DEPTH-1];
    assign bus.retire_valid = retire_valid;
    assign bus.retire_cw    = cw_reg[DEPTH-1];
    assign bus.retire_count = retire_count_reg;

    // Stage registers and the retirement counter. Reset discards all
    // in-flight words without counting them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_reg[k] <= 1'b0;
                cw_reg[k]    <= '0;
                pc_reg[k]    <= '0;
            end
            retire_count_reg <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_reg[k] <= valid_next[k];
                cw_reg[k]    <= cw_next[k];
                pc_reg[k]    <= pc_next[k];
            end
            if (retire_valid) begin
                retire_count_reg <= retire_count_reg + CNT_WIDTH'(1);
            end
        end
    end

    // Flatten the per-stage registers onto the packed output buses.
    always_comb begin
        bus.stage_valid = '0;
        bus.stage_cw    = '0;
        bus.stage_pc    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.stage_valid[k]                      = valid_reg[k];
            bus.stage_cw[k*CW_WIDTH +: CW_WIDTH]    = cw_reg[k];
            bus.stage_pc[k*PC_WIDTH +: PC_WIDTH]    = pc_reg[k];
        end
    end

endmodule

// File: doc/lc3b_cw_pipeline.md
Name: lc3b_cw_pipeline

Overview:
- Parametrised control-word pipeline for the LC-3b core.
- Carries the packed decode control word (opcode, load_cc, load_regfile, aluop, mux selects, mem_read/mem_write) and its PC through DEPTH register stages after decode.
- Handles per-stage stalls with bubble insertion, per-stage flushes and a retirement counter.
- Replaces the hand-written per-stage control-word registers in the datapath.

Parameters:
- CW_WIDTH, 20, width of the packed control word.
- DEPTH, 4, number of pipeline stages after decode (stage 0 youngest, DEPTH-1 oldest/writeback); legal range 2..8.
- PC_WIDTH, 16, width of the PC carried with each word.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents a valid control word.
- in_cw  in  CW_WIDTH  control word from decode.
- in_pc  in  PC_WIDTH  PC of the decoded instruction.
- in_ready  out  1  stage 0 will accept this cycle.
- stall  in  DEPTH  per-stage stall request; bit k holds stage k.
- flush  in  DEPTH  per-stage kill; bit k invalidates stage k.
- stage_valid  out  DEPTH  valid bit per stage.
- stage_cw  out  DEPTH*CW_WIDTH  control word per stage; stage k at bits [k*CW_WIDTH +: CW_WIDTH].
- stage_pc  out  DEPTH*PC_WIDTH  PC per stage, same packing.
- retire_valid  out  1  oldest stage retires this cycle.
- retire_cw  out  CW_WIDTH  control word of the retiring stage (equals stage DEPTH-1 word).
- retire_count  out  CNT_WIDTH  running count of retired instructions.

Behaviour:
- Reset (synchronous, has priority over everything):
  - all stage_valid=0, stage_cw=0, stage_pc=0, retire_count=0.
  - in_ready and retire_valid then follow their combinational equations.
- Hold vector (combinational): h[k] = OR of stall[j] for j = k..DEPTH-1. A downstream stall holds every younger stage.
- in_ready = ~h[0].
- Per-stage next state, evaluated in priority order:
  1. flush[k]=1: valid<=0 and cw<=0; pc unchanged. Applies whether or not stage k is held.
  2. else if h[k]=1: stage k keeps valid, cw and pc.
  3. else, k>0 with h[k-1]=1: bubble inserted; valid<=0, cw<=0, pc<=0.
  4. else, k>0: stage k loads stage k-1 (valid, cw, pc).
  5. else, k=0: loads in_valid, in_cw, in_pc. If in_valid=0 then cw<=0 and pc<=0.
- An invalid stage always holds cw=0, so no load_regfile, load_cc, mem_read or mem_write is asserted by a bubble.
- Flush of stage k does not affect stage k+1 receiving the old stage-k word in the same edge: advance uses pre-edge values.
  - The datapath flushes the younger stages explicitly. A branch resolved in stage k drives flush bits 0..k-1 plus its own bubble policy.
- Retire (combinational): retire_valid = stage_valid[DEPTH-1] & ~stall[DEPTH-1] & ~flush[DEPTH-1]; retire_cw = stage_cw of stage DEPTH-1.
- retire_count increments by 1 on each edge where retire_valid=1. Wraps modulo 2^CNT_WIDTH; no saturation.
- Latency: an accepted word appears in stage 0 one cycle after acceptance and in stage DEPTH-1 DEPTH cycles after acceptance, absent stalls.
- Simultaneous events:
  - flush overrides stall for the same stage.
  - stall on an invalid stage is legal and holds the bubble.
  - in_valid with in_ready=0 is ignored; decode must hold its word.
- Reset mid-operation discards all in-flight words and does not count them.

Test Plan:
- Reset, then in_valid=1 for 4 cycles with in_cw=20'h00001..20'h00004 and PC x3000..x3006; no stall or flush. Each word reaches stage 3 four cycles after acceptance; retire_valid for 4 consecutive cycles; retire_count=4.
- Stream words, assert stall[2] for 2 cycles.
  - Stages 0-2 hold and in_ready=0.
  - Stage 3 receives 2 bubbles (valid=0, cw=0).
  - Flow resumes with no word lost or duplicated; final retire_count equals the number issued.
- Full pipe, assert flush=4'b0011 for 1 cycle. Stages 0-1 become invalid with cw=0; stages 2-3 advance normally. Exactly 2 fewer retirements are counted.
- Assert stall[3] and flush[3] together with stage 3 valid. retire_valid=0, stage 3 becomes invalid, and stages 0-2 hold.
- Preload retire_count to 16'hFFFF by 65535 retirements (or force), then retire one more. retire_count=16'h0000.
- Assert reset with all 4 stages valid and stall[1]=1. Next cycle all stage_valid=0, all cw=0, retire_count=0, in_ready=1.
